ccff_chain_loader: RTL and testbench

Configuration-chain load controller for the I/O tile column. It fetches bitstream words from a valid/ready source and serializes them LSB-first onto the `ccff_head` input of a chain of `CHAIN_LEN` configuration flip-flops. It drives a shift-enable that gates the chain's `prog_clk`. In verify mode it shifts the same stream a second time and checks every bit returning on `ccff_tail` against the bit being shifted in. The block sits between the bitstream source and the head of the I/O tile ccff chain.

---
 rtl/ccff_chain_loader.sv | 94 +++++++++
 tb/tb_ccff_chain_loader.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: fetches bitstream words and shifts them LSB-first into a ccff chain, optionally replaying and checking the stream
module ccff_chain_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 48
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic              verify,
  input  logic [WORD_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int IW = $clog2(WORD_W);
  localparam int BW = CHAIN_LEN > 1 ? $clog2(CHAIN_LEN) : 1;
  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, FINISH} state_t;
  state_t state, state_n;
  logic [WORD_W-1:0] sr, sr_n;
  logic [IW-1:0] idx, idx_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic pass, pass_n, vfy, vfy_n, err_n;
  assign bs_ready = state == FETCH;
  always_comb begin
    state_n = state;
    sr_n    = sr;
    idx_n   = idx;
    bcnt_n  = bcnt;
    pass_n  = pass;
    vfy_n   = vfy;
    err_n   = err;
    case (state)
      IDLE: if (start) begin
        vfy_n   = verify;
        err_n   = 1'b0;
        bcnt_n  = '0;
        pass_n  = 1'b0;
        state_n = FETCH;
      end
      FETCH: if (bs_valid) begin
        sr_n    = bs_data;
        idx_n   = '0;
        state_n = SHIFT;
      end
      SHIFT: begin
        sr_n   = sr >> 1;
        idx_n  = idx + IW'(1);
        bcnt_n = bcnt + BW'(1);
        // the tail now returns the pass-0 bit at the same position as the head
        if (pass && ccff_tail != ccff_head) err_n = 1'b1;
        if (bcnt == BW'(CHAIN_LEN - 1)) begin
          if (vfy && !pass) begin
            pass_n  = 1'b1;
            bcnt_n  = '0;
            state_n = FETCH;
          end else state_n = FINISH;
        end else if (idx == IW'(WORD_W - 1)) state_n = FETCH;
      end
      default: state_n = IDLE;
    endcase
  end
  // outputs are registered from next-state so they line up with the state they describe
  always_ff @(posedge prog_clk or negedge pReset_n)
    if (!pReset_n) begin
      state         <= IDLE;
      sr            <= '0;
      idx           <= '0;
      bcnt          <= '0;
      pass          <= 1'b0;
      vfy           <= 1'b0;
      err           <= 1'b0;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_n;
      sr            <= sr_n;
      idx           <= idx_n;
      bcnt          <= bcnt_n;
      pass          <= pass_n;
      vfy           <= vfy_n;
      err           <= err_n;
      ccff_head     <= state_n == SHIFT && sr_n[0];
      ccff_shift_en <= state_n == SHIFT;
      busy          <= state_n != IDLE;
      done          <= state_n == FINISH;
    end
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: randomized loads checked against a bit-stream model of the chain loader
module tb_ccff_chain_loader;
  localparam int W = 8, L = 12, WPP = (L + W - 1) / W;
  logic prog_clk = 0, pReset_n = 0, start = 0, verify = 0, bs_valid = 0;
  logic [W-1:0] bs_data = '0;
  logic bs_ready, ccff_head, ccff_shift_en, ccff_tail, busy, done, err;
  logic [L-1:0] chain = '0;
  logic [W-1:0] words [2*WPP];
  int stall [2*WPP];
  int n_chk = 0, n_err = 0;
  always #5 prog_clk = ~prog_clk;
  always @(posedge prog_clk) if (ccff_shift_en) chain <= {chain[L-2:0], ccff_head};
  assign ccff_tail = chain[L-1];
  ccff_chain_loader #(.WORD_W(W), .CHAIN_LEN(L)) dut (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .start(start), .verify(verify),
    .bs_data(bs_data), .bs_valid(bs_valid), .bs_ready(bs_ready),
    .ccff_head(ccff_head), .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail),
    .busy(busy), .done(done), .err(err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic set_words(input logic [W-1:0] a, b, c, d);
    words[0] = a; words[1] = b; words[2] = c; words[3] = d;
    for (int j = 0; j < 2 * WPP; j++) stall[j] = 0;
  endtask
  task automatic run_load(input bit v, input bit poke);
    int passes = v ? 2 : 1;
    int nw = passes * WPP;
    int hs = 0, sl = stall[0], sc = 0, cyc = 0, tot = 0, m = -1, bad = 0;
    int done_cyc = -1, err_cyc = -1, exp_err = -1;
    logic eb [2*L];
    for (int p = 0; p < passes; p++)
      for (int k = 0; k < L; k++) eb[p*L+k] = words[p*WPP + k/W][k%W];
    for (int k = 0; k < L; k++) if (v && m < 0 && eb[L+k] != eb[k]) m = k;
    for (int j = 0; j < nw; j++) tot += stall[j];
    start = 1;
    verify = v;
    while (cyc < 400) begin
      @(negedge prog_clk);
      cyc++;
      start = 0;
      verify = 1'($urandom_range(0, 1));
      if (cyc == 1) begin
        chk("busy_at_fetch", 32'(busy), 1);
        chk("ready_at_fetch", 32'(bs_ready), 1);
      end
      if (done_cyc >= 0) begin
        chk("done_one_cycle", 32'(done), 0);
        chk("busy_after_done", 32'(busy), 0);
        chk("err_after_done", 32'(err), 32'(m >= 0));
        break;
      end
      if (ccff_shift_en) begin
        if (sc < passes * L) chk("head_bit", 32'(ccff_head), 32'(eb[sc]));
        sc++;
        if (m >= 0 && sc == L + m + 1) exp_err = cyc + 1;
      end
      if (done) done_cyc = cyc;
      if (err && err_cyc < 0) err_cyc = cyc;
      if (bs_ready && ccff_shift_en) bad++;
      if (bs_ready && hs < nw) begin
        if (sl > 0) begin
          bs_valid = 0;
          sl--;
        end else begin
          bs_valid = 1;
          bs_data = words[hs];
          hs++;
          sl = hs < nw ? stall[hs] : 0;
        end
      end else begin
        if (bs_ready) bad++;
        bs_valid = 1'($urandom_range(0, 1));
        bs_data = words[hs < nw ? hs : 0];
      end
      if (poke && sc == 3) begin
        start = 1;
        verify = !v;
      end
    end
    bs_valid = 0;
    chk("shift_cycles", sc, passes * L);
    chk("handshakes", hs, nw);
    chk("done_cycle", done_cyc, 1 + nw + tot + passes * L);
    chk("err_rise_cycle", err_cyc, exp_err);
    chk("ready_while_shifting", bad, 0);
  endtask
  initial begin
    int n;
    int sw, sb;
    repeat (2) @(negedge prog_clk);
    chk("reset_outputs", 32'({busy, done, err, ccff_shift_en, ccff_head, bs_ready}), 0);
    pReset_n = 1;
    @(negedge prog_clk);
    set_words(8'hA5, 8'h3C, 8'h00, 8'h00);
    run_load(0, 0);
    set_words(8'hFF, 8'h0F, 8'h00, 8'h00);
    run_load(0, 1);
    set_words(8'hA5, 8'h3C, 8'h00, 8'h00);
    stall[1] = 5;
    run_load(0, 0);
    set_words(8'hA5, 8'h3C, 8'hA5, 8'h3C);
    run_load(1, 0);
    set_words(8'hA5, 8'h3C, 8'h85, 8'h3C);
    run_load(1, 1);
    repeat (3) @(negedge prog_clk);
    chk("err_sticky_idle", 32'(err), 1);
    set_words(8'hA5, 8'h3C, 8'h00, 8'h00);
    run_load(0, 0);
    for (int t = 0; t < 25; t++) begin
      for (int j = 0; j < WPP; j++) begin
        words[j] = W'($urandom);
        words[WPP+j] = words[j];
      end
      for (int j = 0; j < 2 * WPP; j++) stall[j] = $urandom_range(0, 1) ? 0 : $urandom_range(1, 3);
      if ($urandom_range(0, 2) == 0) begin
        sw = WPP + $urandom_range(0, WPP - 1);
        sb = $urandom_range(0, W - 1);
        words[sw][sb] = !words[sw][sb];
      end
      run_load(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    start = 1;
    verify = 0;
    bs_data = 8'hA5;
    n = 0;
    for (int c = 0; c < 100 && n < 7; c++) begin
      @(negedge prog_clk);
      start = 0;
      bs_valid = 1;
      if (ccff_shift_en) n++;
    end
    chk("shifts_before_reset", n, 7);
    pReset_n = 0;
    #1;
    chk("midload_reset", 32'({busy, done, err, ccff_shift_en, ccff_head, bs_ready}), 0);
    @(negedge prog_clk);
    pReset_n = 1;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge prog_clk);
      if (done || busy) n++;
    end
    chk("no_done_after_reset", n, 0);
    bs_valid = 0;
    set_words(8'h5A, 8'hC3, 8'h5A, 8'hC3);
    run_load(1, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
